uart_echo_fifo_ctrl: RTL
========================

// Module: uart_echo_fifo_ctrl
// PURPOSE
//  Parametrised echo controller between the UART receiver and UART transmitter.
//  Buffers received characters in a DEPTH-entry FIFO and applies a runtime-selectable
//  case transform before retransmitting them.
//  Adds overflow and parity-error reporting, and drives the board LEDs.
//  Sits at top level: rx side fed by UARTRx outputs, tx side drives UARTTx data/start/done.
// PARAMETERS
//  DATA_W   8   character width; 7 or 8 only
//  DEPTH    16  FIFO entries; power of 2, >=2; ADDR_W = $clog2(DEPTH)
//  BLINK_W  23  parity-error LED toggle period = 2**BLINK_W cycles (>=2)
// PORTS
//  clk_50M        in   1          system clock
//  reset          in   1          synchronous, active-high reset
//  rx_data        in   DATA_W     received character from UARTRx
//  rx_valid       in   1          1-cycle strobe: rx_data/rx_parity_err valid
//  rx_parity_err  in   1          parity error on the current rx_valid
//  mode           in   2          0 pass, 1 to-upper, 2 to-lower, 3 swap-case
//  tx_data        out  DATA_W     character to UARTTx
//  tx_start       out  1          1-cycle start strobe to UARTTx
//  tx_done        in   1          UARTTx finished the current character
//  leds_out       out  DATA_W     LED pattern
//  fifo_level     out  ADDR_W+1   current FIFO occupancy, 0..DEPTH
//  overflow       out  1          sticky: a good character was dropped, FIFO full
//  err_count      out  8          saturating count of parity errors
// BEHAVIOUR
//  Reset (all sync on posedge clk_50M when reset=1):
//   - tx_start=0, tx_data=0, fifo_level=0, overflow=0, err_count=0.
//   - leds_out = alternating 1010.. pattern, MSB=1.
//   - FSM=IDLE; FIFO pointers=0. Reset mid-transfer abandons the character; nothing is retained.
//  Accept (edge where rx_valid=1):
//   - rx_parity_err=0: transform rx_data by mode, sampled that cycle.
//     - Uppercase is 65..90; lowercase is 97..122. Add or subtract 32 as mode requires; others unchanged.
//     - Push to the FIFO.
//     - leds_out <= transformed value; blink mode exits.
//   - rx_parity_err=1: nothing pushed.
//     - err_count += 1, saturating at 255.
//     - Enter blink: leds_out = all ones. Toggle all-ones/all-zeros every 2**BLINK_W cycles.
//     - A further error restarts the blink timer with leds all ones.
//  FIFO:
//   - full = level==DEPTH; empty = level==0. Pointers wrap modulo DEPTH.
//   - Push while full and no pop that edge: character dropped, overflow <= 1 (reset clears only).
//   - Push while full with pop same edge: accepted; level stays DEPTH.
//   - Push+pop same edge otherwise: level unchanged.
//  TX FSM:
//   - IDLE: if !empty, go to START.
//   - START: tx_data <= head, pop, tx_start=1 for exactly this one cycle; go to WAIT.
//   - WAIT: hold tx_data stable; on tx_done go to IDLE.
//   - tx_done outside WAIT is ignored.
//  Latency: good rx_valid at edge k with FIFO empty and FSM IDLE -> tx_start high in the cycle after edge k+1.
//  Back-to-back rx_valid on consecutive cycles is legal; each is accepted independently.
//  mode change affects only characters accepted after it; FIFO content is never re-transformed.
// TESTING
//  T1 reset:
//   - After reset -> tx_start=0, fifo_level=0, overflow=0, err_count=0.
//   - leds_out=8'hAA (DATA_W=8).
//  T2 echo:
//   - mode=3; rx 8'h61 'a' -> tx_data=8'h41, one tx_start pulse 2 edges later.
//   - tx_done returns FSM to IDLE.
//   - rx 8'h5A -> tx_data 8'h7A.
//   - rx 8'h31 -> tx_data 8'h31 unchanged.
//  T3 fill/overflow (DEPTH=16):
//   - Hold tx_done=0 and push 18 good chars.
//   - Expect fifo_level=16 (1 in flight) and overflow=1.
//   - Release tx_done per char: the 17 accepted chars come out in order; the 18th is never sent.
//  T4 full+pop same edge:
//   - FIFO full, push coincident with START pop -> level stays 16; new char later transmitted.
//  T5 parity:
//   - rx_parity_err=1 (BLINK_W=3) -> nothing pushed, err_count=1.
//   - leds 8'hFF, then 8'h00 8 cycles later, then 8'hFF again.
//   - Next good 8'h41, mode=0 -> leds 8'h41.
//   - 300 errors -> err_count=255.
//  T6 reset mid-operation:
//   - Assert reset during WAIT with 5 queued -> next cycle fifo_level=0, no tx_start.
//   - Outputs match T1.

Source files
------------

// File: rtl/uart_echo_fifo_ctrl.sv
// Echo controller between UARTRx and UARTTx: case-transforms received characters,
// buffers them in a FIFO, retransmits them one at a time and drives status LEDs.
module uart_echo_fifo_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned BLINK_W = 23,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_parity_err,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic [DATA_W-1:0] leds_out,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  function automatic logic [DATA_W-1:0] alt_pattern();
    logic [DATA_W-1:0] p;
    p = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      p[i] = (((int'(DATA_W) - 1 - i) % 2) == 0);
    end
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] ch, input logic [1:0] m);
    logic [7:0]        c;
    logic              is_up;
    logic              is_lo;
    logic [DATA_W-1:0] r;
    c     = 8'(ch);
    is_up = (c >= 8'd65) && (c <= 8'd90);
    is_lo = (c >= 8'd97) && (c <= 8'd122);
    r     = ch;
    case (m)
      2'd1:    if (is_lo) r = ch - DATA_W'(32);
      2'd2:    if (is_up) r = ch + DATA_W'(32);
      2'd3: begin
        if (is_up)      r = ch + DATA_W'(32);
        else if (is_lo) r = ch - DATA_W'(32);
      end
      default: r = ch;
    endcase
    return r;
  endfunction

  localparam logic [DATA_W-1:0] LedReset  = alt_pattern();
  localparam logic [ADDR_W:0]   LevelFull = (ADDR_W + 1)'(DEPTH);

  state_e            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   level_q;
  logic              overflow_q;
  logic [7:0]        err_q;
  logic [DATA_W-1:0] leds_q;
  logic              blink_q;
  logic [BLINK_W-1:0] blink_cnt_q;

  logic              empty;
  logic              full;
  logic              pop;
  logic              push_req;
  logic              push_ok;
  logic [DATA_W-1:0] rx_xf;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LevelFull);
  assign pop      = (state_q == StIdle) && !empty;
  assign push_req = rx_valid && !rx_parity_err;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign rx_xf    = xform(rx_data, mode);

  always_ff @(posedge clk_50M) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_xf;
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && full && !pop) overflow_q <= 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Head is latched on entry to StStart so tx_data is valid while tx_start is high.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q  <= StIdle;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_q  <= StStart;
            tx_start <= 1'b1;
            tx_data  <= mem_q[rd_ptr_q];
          end
        end
        StStart: state_q <= StWait;
        StWait:  if (tx_done) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      leds_q      <= LedReset;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      err_q       <= '0;
    end else if (rx_valid && rx_parity_err) begin
      if (err_q != 8'hFF) err_q <= err_q + 1'b1;
      leds_q      <= '1;
      blink_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else if (rx_valid) begin
      leds_q  <= rx_xf;
      blink_q <= 1'b0;
    end else if (blink_q) begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
      if (&blink_cnt_q) leds_q <= ~leds_q;
    end
  end

  assign leds_out   = leds_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign err_count  = err_q;

endmodule
